btn_event_decoder: RTL
======================

# btn_event_decoder

Consumes the clean, debounced button levels produced by the front-panel debouncers and turns them into single-cycle event pulses for the CPU test harness: press, release, long-press and auto-repeat. It sits between the per-button debouncers and the control logic (step/run/reset-PC buttons), so downstream logic never does its own edge detection or hold timing. All buttons are handled by identical, independent per-button state machines.

## Interface

- N_BTN, 5, number of buttons handled (1..16)
- LONG_CYC, 50_000_000, cycles a button must stay down before Long_Pulse (>= 2)
- REPEAT_CYC, 10_000_000, period of Repeat_Pulse while held past long-press (>= 2)
- Clock  input  1  sole clock; all logic on posedge
- Reset_n  input  1  synchronous, active-low reset
- BTN_Level  input  N_BTN  debounced button levels, 1 = pressed, synchronous to Clock
- Press_Pulse  output  N_BTN  one-cycle pulse per press
- Release_Pulse  output  N_BTN  one-cycle pulse per release
- Long_Pulse  output  N_BTN  one-cycle pulse when hold reaches LONG_CYC
- Repeat_Pulse  output  N_BTN  one-cycle pulse every REPEAT_CYC after long-press
- BTN_Held  output  N_BTN  1 while the button's FSM is in DOWN or HELD
- Press_Count  output  8  total presses across all buttons, wraps 255 -> 0

## Operation

- BTN_Level registered once into lvl_q; FSM acts on lvl_q only.
- Per-button FSM states: IDLE, DOWN, HELD; per-button counter cnt, width clog2(max(LONG_CYC, REPEAT_CYC)).
- IDLE: lvl_q=1 -> DOWN, cnt <= 0, Press_Pulse <= 1.
- DOWN: lvl_q=0 -> IDLE, Release_Pulse <= 1. Else if cnt == LONG_CYC-1 -> HELD, cnt <= 0, Long_Pulse <= 1. Else cnt++.
- HELD: lvl_q=0 -> IDLE, Release_Pulse <= 1. Else if cnt == REPEAT_CYC-1 -> cnt <= 0, Repeat_Pulse <= 1 (when repeat compiled in). Else cnt++.
- Release has priority over Long/Repeat on the same edge: only Release_Pulse fires.
- All pulse outputs are registered and default to 0 every cycle not listed above.
- Press_Count += number of Press_Pulse bits set in the same cycle (popcount, several simultaneous presses counted individually), modulo 256.
- Buttons fully independent; simultaneous events on different bits never interact except in Press_Count.

## Timing

- Reset (Reset_n=0 at posedge): lvl_q=0, all FSMs IDLE, cnt=0, all pulse outputs 0, BTN_Held=0, Press_Count=0. Applies mid-hold: no Release_Pulse generated by reset.
- Button held at 1 through reset release: treated as a new press; Press_Pulse 2 cycles after first edge with Reset_n=1.
- Latency: BTN_Level change sampled at edge E0 -> corresponding Press/Release_Pulse high from E1 to E2 (2 edges input-to-output).
- Press_Pulse at E1 -> Long_Pulse at E1+LONG_CYC -> Repeat_Pulse at E1+LONG_CYC+k*REPEAT_CYC, k >= 1.
- BTN_Held registered; rises with Press_Pulse, falls with Release_Pulse.
- Press_Count updated one edge after Press_Pulse is visible.

## Configuration

- Macro BTN_AUTO_REPEAT_EN.
- Defined: HELD counts and emits Repeat_Pulse as above.
- Undefined: Repeat_Pulse tied to 0, HELD counter frozen at 0 (no toggling); all other behaviour identical.

## Test plan

Parameters for bench: N_BTN=2, LONG_CYC=8, REPEAT_CYC=4, BTN_AUTO_REPEAT_EN defined.
- Reset: drive Reset_n=0 with BTN_Level=2'b11 for 3 cycles -> all outputs 0, Press_Count=0; release reset -> Press_Pulse=2'b11 two edges later, Press_Count=2 one edge after.
- Short press: BTN_Level[0]=1 for 5 cycles -> one Press_Pulse[0], one Release_Pulse[0] 5 cycles later, no Long_Pulse.
- Long hold: BTN_Level[1]=1 for 20 cycles -> Long_Pulse[1] 8 cycles after Press_Pulse[1], Repeat_Pulse[1] at +12 and +16, then Release_Pulse[1].
- Release on threshold: release timed so lvl_q falls on the edge cnt==7 -> Release_Pulse only, no Long_Pulse.
- Wrap: 256 short presses on button 0 -> Press_Count returns to 0.
- Build without BTN_AUTO_REPEAT_EN, repeat long-hold test -> Long_Pulse present, Repeat_Pulse never asserted.

Source files
------------

// File: rtl/btn_event_decoder.sv
// btn_event_decoder: turns debounced button levels into press/release/long/repeat pulses and a press counter.
//   Ports: Clock, Reset_n (sync, active-low), BTN_Level[N_BTN] in; Press_Pulse, Release_Pulse,
//   Long_Pulse, Repeat_Pulse, BTN_Held [N_BTN] and Press_Count[8] out. Macro BTN_AUTO_REPEAT_EN enables Repeat_Pulse.
module btn_event_decoder #(
  parameter int N_BTN = 5,
  parameter int LONG_CYC = 50_000_000,
  parameter int REPEAT_CYC = 10_000_000
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic [N_BTN-1:0] BTN_Level,
  output logic [N_BTN-1:0] Press_Pulse,
  output logic [N_BTN-1:0] Release_Pulse,
  output logic [N_BTN-1:0] Long_Pulse,
  output logic [N_BTN-1:0] Repeat_Pulse,
  output logic [N_BTN-1:0] BTN_Held,
  output logic [7:0]       Press_Count
);
  localparam int MAX_CYC = LONG_CYC > REPEAT_CYC ? LONG_CYC : REPEAT_CYC;
  localparam int CW = $clog2(MAX_CYC);
  localparam logic [CW-1:0] LONG_END = CW'(LONG_CYC - 1);
`ifdef BTN_AUTO_REPEAT_EN
  localparam logic [CW-1:0] REP_END = CW'(REPEAT_CYC - 1);
`endif
  typedef enum logic [1:0] {S_IDLE, S_DOWN, S_HELD} state_t;
  state_t           r_state [N_BTN];
  state_t           w_state_nxt [N_BTN];
  logic [CW-1:0]    r_cnt [N_BTN];
  logic [CW-1:0]    w_cnt_nxt [N_BTN];
  logic [N_BTN-1:0] r_lvl, r_press, r_rel, r_long, r_rep, r_held;
  logic [N_BTN-1:0] w_press, w_rel, w_long, w_rep;
  logic [7:0]       r_count, w_pop;
  always_comb begin
    w_press = '0;
    w_rel = '0;
    w_long = '0;
    w_rep = '0;
    for (int b = 0; b < N_BTN; b++) begin
      w_state_nxt[b] = r_state[b];
      w_cnt_nxt[b] = r_cnt[b];
      case (r_state[b])
        S_IDLE: if (r_lvl[b]) begin
          w_state_nxt[b] = S_DOWN;
          w_cnt_nxt[b] = '0;
          w_press[b] = 1'b1;
        end
        S_DOWN: if (!r_lvl[b]) begin
          w_state_nxt[b] = S_IDLE;
          w_rel[b] = 1'b1;
        end else if (r_cnt[b] == LONG_END) begin
          w_state_nxt[b] = S_HELD;
          w_cnt_nxt[b] = '0;
          w_long[b] = 1'b1;
        end else begin
          w_cnt_nxt[b] = r_cnt[b] + 1'b1;
        end
        S_HELD: if (!r_lvl[b]) begin
          w_state_nxt[b] = S_IDLE;
          w_rel[b] = 1'b1;
        end else begin
`ifdef BTN_AUTO_REPEAT_EN
          w_cnt_nxt[b] = r_cnt[b] == REP_END ? '0 : r_cnt[b] + 1'b1;
          w_rep[b] = r_cnt[b] == REP_END;
`else
          w_cnt_nxt[b] = '0;
`endif
        end
        default: w_state_nxt[b] = S_IDLE;
      endcase
    end
  end
  // Count every press visible this cycle, so simultaneous presses each add one.
  always_comb begin
    w_pop = '0;
    for (int b = 0; b < N_BTN; b++) w_pop = w_pop + 8'(r_press[b]);
  end
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      r_lvl <= '0;
      r_press <= '0;
      r_rel <= '0;
      r_long <= '0;
      r_rep <= '0;
      r_held <= '0;
      r_count <= '0;
      for (int b = 0; b < N_BTN; b++) begin
        r_state[b] <= S_IDLE;
        r_cnt[b] <= '0;
      end
    end else begin
      r_lvl <= BTN_Level;
      r_press <= w_press;
      r_rel <= w_rel;
      r_long <= w_long;
      r_rep <= w_rep;
      r_count <= r_count + w_pop;
      for (int b = 0; b < N_BTN; b++) begin
        r_state[b] <= w_state_nxt[b];
        r_cnt[b] <= w_cnt_nxt[b];
        r_held[b] <= w_state_nxt[b] != S_IDLE;
      end
    end
  end
  assign Press_Pulse = r_press;
  assign Release_Pulse = r_rel;
  assign Long_Pulse = r_long;
  assign Repeat_Pulse = r_rep;
  assign BTN_Held = r_held;
  assign Press_Count = r_count;
endmodule
